// File: rtl/adxl345_spi_responder_pkg.sv
// Shared definitions for the ADXL345 SPI responder: register map,
// FSM state encoding and the writable-register test.
package adxl_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } spi_state_t;

    // Only the three configuration registers accept writes.
    function automatic logic is_writable(input logic [5:0] addr);
        return (addr == ADDR_BW_RATE) || (addr == ADDR_POWER_CTL) ||
               (addr == ADDR_DATA_FORMAT);
    endfunction

endpackage

// File: rtl/adxl345_spi_responder_if.sv
// Four-wire SPI bus seen by the responder, plus the SDO output enable.
interface adxl345_spi_responder_if;

    logic cs_n;
    logic spc;
    logic sdi;
    logic sdo;
    logic sdo_oe;

    modport master (output cs_n, spc, sdi, input sdo, sdo_oe);
    modport slave  (input cs_n, spc, sdi, output sdo, sdo_oe);

endinterface

// File: rtl/adxl345_spi_responder_sync.sv
// Brings CS/SPC/SDI into the i_clk domain and detects CS and SPC edges.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_pin,
    input  logic spc_pin,
    input  logic sdi_pin,
    output logic sdi,
    output logic spc_rise,
    output logic spc_fall,
    output logic cs_rise,
    output logic cs_fall
);

    logic [SYNC_STAGES-1:0] cs_chain;
    logic [SYNC_STAGES-1:0] spc_chain;
    logic [SYNC_STAGES-1:0] sdi_chain;
    logic                   cs_prev;
    logic                   spc_prev;
    logic                   cs_sync;
    logic                   spc_sync;

    // Synchronizer chains reset to bus idle levels so no edge appears out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_chain  <= '1;
            spc_chain <= '1;
            sdi_chain <= '0;
            cs_prev   <= 1'b1;
            spc_prev  <= 1'b1;
        end else begin
            cs_chain  <= {cs_chain[SYNC_STAGES-2:0], cs_pin};
            spc_chain <= {spc_chain[SYNC_STAGES-2:0], spc_pin};
            sdi_chain <= {sdi_chain[SYNC_STAGES-2:0], sdi_pin};
            cs_prev   <= cs_sync;
            spc_prev  <= spc_sync;
        end
    end

    assign cs_sync  = cs_chain[SYNC_STAGES-1];
    assign spc_sync = spc_chain[SYNC_STAGES-1];
    assign sdi      = sdi_chain[SYNC_STAGES-1];

    assign spc_rise = spc_sync & ~spc_prev;
    assign spc_fall = ~spc_sync & spc_prev;
    assign cs_rise  = cs_sync & ~cs_prev;
    assign cs_fall  = ~cs_sync & cs_prev;

endmodule

// File: rtl/adxl345_spi_responder.sv
// ADXL345 register-interface emulator on a mode-3 SPI bus. Serves host
// supplied X/Y/Z samples and a few writable configuration registers.
module adxl345_spi_responder
    import adxl_pkg::*;
#(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter logic [7:0] BW_RATE_RST = 8'h0A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    adxl345_spi_responder_if.slave        spi,
    input  logic signed [15:0]            i_x,
    input  logic signed [15:0]            i_y,
    input  logic signed [15:0]            i_z,
    input  logic                          i_sample_valid,
    output logic [7:0]                    o_power_ctl,
    output logic [7:0]                    o_data_format,
    output logic [7:0]                    o_bw_rate,
    output logic                          o_wr_strobe,
    output logic [5:0]                    o_wr_addr
);

    logic       sdi, spc_rise, spc_fall, cs_rise, cs_fall;
    spi_state_t state, state_next;
    logic [2:0] bit_cnt;
    logic [7:0] shift_in, tx_shift, cmd_byte, rd_data;
    logic       rw, mb, sdo;
    logic [5:0] addr, addr_next, rd_addr;
    logic [15:0] shadow_x, shadow_y, shadow_z;
    logic [15:0] pend_x, pend_y, pend_z;
    logic       pend_valid;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (i_clk),
        .rst      (i_rst),
        .cs_pin   (spi.cs_n),
        .spc_pin  (spi.spc),
        .sdi_pin  (spi.sdi),
        .sdi      (sdi),
        .spc_rise (spc_rise),
        .spc_fall (spc_fall),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall)
    );

    assign cmd_byte  = {shift_in[6:0], sdi};
    assign addr_next = mb ? addr + 6'd1 : addr;
    assign rd_addr   = (state == CMD) ? cmd_byte[5:0] : addr_next;

    // Register read mux; addresses the byte about to be loaded into tx_shift.
    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_DEVID:       rd_data = DEVID;
            ADDR_BW_RATE:     rd_data = o_bw_rate;
            ADDR_POWER_CTL:   rd_data = o_power_ctl;
            ADDR_DATA_FORMAT: rd_data = o_data_format;
            ADDR_DATAX0:      rd_data = shadow_x[7:0];
            ADDR_DATAX1:      rd_data = shadow_x[15:8];
            ADDR_DATAY0:      rd_data = shadow_y[7:0];
            ADDR_DATAY1:      rd_data = shadow_y[15:8];
            ADDR_DATAZ0:      rd_data = shadow_z[7:0];
            ADDR_DATAZ1:      rd_data = shadow_z[15:8];
            default:          rd_data = 8'h00;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: CS edges override everything, a CS fall always restarts CMD.
    always_comb begin
        state_next = state;
        if (cs_rise)
            state_next = IDLE;
        else if (cs_fall)
            state_next = CMD;
        else if (state == CMD && spc_rise && bit_cnt == 3'd7)
            state_next = DATA;
    end

    // Shift datapath, address tracking and register commits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt       <= '0;
            shift_in      <= '0;
            tx_shift      <= '0;
            rw            <= 1'b0;
            mb            <= 1'b0;
            addr          <= '0;
            sdo           <= 1'b1;
            o_power_ctl   <= 8'h00;
            o_data_format <= 8'h00;
            o_bw_rate     <= BW_RATE_RST;
            o_wr_strobe   <= 1'b0;
            o_wr_addr     <= '0;
        end else begin
            o_wr_strobe <= 1'b0;
            if (cs_rise) begin
                sdo <= 1'b1;
            end else if (cs_fall) begin
                bit_cnt <= '0;
                sdo     <= 1'b0;
            end else begin
                case (state)
                    CMD: begin
                        if (spc_rise) begin
                            shift_in <= cmd_byte;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rw       <= cmd_byte[7];
                                mb       <= cmd_byte[6];
                                addr     <= cmd_byte[5:0];
                                tx_shift <= rd_data;
                            end
                        end
                    end
                    DATA: begin
                        if (rw) begin
                            if (spc_fall) begin
                                sdo      <= tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                            if (spc_rise) begin
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    addr     <= addr_next;
                                    tx_shift <= rd_data;
                                end
                            end
                        end else if (spc_rise) begin
                            shift_in <= cmd_byte;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (is_writable(addr)) begin
                                    case (addr)
                                        ADDR_BW_RATE:   o_bw_rate     <= cmd_byte;
                                        ADDR_POWER_CTL: o_power_ctl   <= cmd_byte;
                                        default:        o_data_format <= cmd_byte;
                                    endcase
                                    o_wr_strobe <= 1'b1;
                                    o_wr_addr   <= addr;
                                end
                                addr <= addr_next;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sample shadowing: a burst only ever sees the sample present when CS fell.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow_x   <= '0;
            shadow_y   <= '0;
            shadow_z   <= '0;
            pend_x     <= '0;
            pend_y     <= '0;
            pend_z     <= '0;
            pend_valid <= 1'b0;
        end else if (i_sample_valid && (state == IDLE || cs_rise)) begin
            shadow_x   <= i_x;
            shadow_y   <= i_y;
            shadow_z   <= i_z;
            pend_valid <= 1'b0;
        end else if (i_sample_valid) begin
            pend_x     <= i_x;
            pend_y     <= i_y;
            pend_z     <= i_z;
            pend_valid <= 1'b1;
        end else if (cs_rise && pend_valid) begin
            shadow_x   <= pend_x;
            shadow_y   <= pend_y;
            shadow_z   <= pend_z;
            pend_valid <= 1'b0;
        end
    end

    assign spi.sdo    = sdo;
    assign spi.sdo_oe = (state != IDLE);

endmodule

// File: doc/adxl345_spi_responder.md
Name: adxl345_spi_responder

Overview:
SPI responder (slave) that emulates the ADXL345 register interface on the 4-wire bus (CS, SPC, SDI, SDO), mode 3.
- Used as the far end for our accelerometer-reading SPI masters: an on-FPGA loopback target for bring-up, and a board-to-board link where one board serves tilt data to another.
- Host-side logic supplies X/Y/Z samples; the block serves them through DATAX0..DATAZ1 along with a small set of writable config registers.

Parameters:
DEVID, 8'hE5, value returned at register 0x00
BW_RATE_RST, 8'h0A, reset value of BW_RATE (0x2C)
SYNC_STAGES, 2, synchronizer depth on CS/SPC/SDI (allowed range 2..3)

Ports:
i_clk  in  1  system clock; SPC must be at most i_clk/8
i_rst  in  1  synchronous reset, active-high
i_CS  in  1  chip select, active-low
i_SPC  in  1  SPI clock, idles high
i_SDI  in  1  master-to-responder data
o_SDO  out  1  responder-to-master data
o_SDO_oe  out  1  SDO output enable; high only while CS is low
i_x / i_y / i_z  in  16 each  signed sample, two's complement
i_sample_valid  in  1  one-cycle strobe; new x/y/z are present
o_power_ctl  out  8  POWER_CTL register (0x2D)
o_data_format  out  8  DATA_FORMAT register (0x31)
o_bw_rate  out  8  BW_RATE register (0x2C)
o_wr_strobe  out  1  one-cycle pulse after any accepted register write
o_wr_addr  out  6  address of the last accepted write

Behaviour:
Reset (i_rst high at a rising i_clk edge):
- o_SDO=1, o_SDO_oe=0, o_power_ctl=0, o_data_format=0, o_bw_rate=BW_RATE_RST.
- Shadow samples=0, o_wr_strobe=0, o_wr_addr=0, state=IDLE.
- Reset mid-transaction drops the transaction; no write commits.

Pin sampling:
- CS, SPC and SDI pass through SYNC_STAGES flops, then edge detection.
- Rise = SPC rising; fall = SPC falling; cs_fall / cs_rise likewise.
- Output latency: SDO changes SYNC_STAGES+1 i_clk cycles after the pin-level SPC fall.

Protocol:
- MSB first. SDI is sampled on rise; SDO is updated on fall.
- Command byte: bit7 = R/W (1 = read), bit6 = MB, bits5:0 = address.

FSM states: IDLE, CMD, DATA.
- IDLE: o_SDO_oe=0. On cs_fall, clear bit_cnt and go to CMD.
- CMD: shift in 8 bits on rises. After the 8th rise, latch rw, mb and addr, then go to DATA.
  - For a read, load the tx byte from the register at addr. The first fall after the 8th rise drives bit7.
  - SDO=0 throughout CMD.
- DATA: bit_cnt counts 0..7 per byte.
  - Read: shift out on each fall. After the 8th rise of a byte, advance addr and load the next byte.
  - Write: shift in on each rise. On the 8th rise, commit to a writable addr, pulse o_wr_strobe for one cycle and set o_wr_addr. Then advance addr.
  - Address advance: if mb=1, addr = addr+1 mod 64 (0x3F wraps to 0x00). If mb=0, addr stays the same.
- cs_rise in any state: go to IDLE, o_SDO_oe=0, o_SDO=1. A partial byte is discarded (no commit, no strobe).

Register map:
- 0x00 DEVID: read-only.
- 0x2C, 0x2D, 0x31: read/write.
- 0x32..0x37: read-only; {x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8]}, low byte first.
- Unmapped addresses read 0x00. Writes to read-only or unmapped addresses are ignored and produce no strobe.

Sample coherency:
- i_sample_valid while in IDLE: copy i_x/i_y/i_z to the shadow registers in the same cycle.
- i_sample_valid while CS is low: hold the sample in a pending buffer. Apply it on cs_rise; a later strobe overwrites the pending sample.
- Guarantee: a multi-byte burst never mixes two samples.

Simultaneous events:
- cs_rise and i_sample_valid in the same cycle: apply the new strobe's sample.
- cs_fall without a preceding cs_rise (glitch): restart CMD.

Decomposition:
Package adxl_pkg holds:
- Register address constants: ADDR_DEVID, ADDR_BW_RATE, ADDR_POWER_CTL, ADDR_DATA_FORMAT, ADDR_DATAX0..ADDR_DATAZ1.
- The FSM state enum (IDLE/CMD/DATA).
- A function is_writable(addr).

One sub-module: spi_pin_sync (SYNC_STAGES synchronizer plus rise/fall detection for CS and SPC, sync-only for SDI).

Test Plan:
- Reset, then read 0x00 with single-byte mode (command 0x80) -> SDO shifts 0xE5; o_SDO_oe=1 only while CS is low.
- Strobe x=16'h1234, y=16'hFFFE, z=16'h0100 in IDLE; burst read command 0xF2 for 6 bytes -> 34 12 FE FF 00 01.
- Write command 0x2D with data 0x08 -> o_power_ctl=0x08, one-cycle o_wr_strobe, o_wr_addr=0x2D; read back 0xAD returns 0x08.
- Start a 0xF2 burst, strobe x=16'h5555 after byte 2, finish the burst -> all 6 bytes come from the old sample; after CS rises, re-read gives 0x55 0x55.
- Write 0x31 but raise CS after 5 data bits -> o_data_format stays 0x00 and no strobe; write 0x00 with 0x12 -> ignored, DEVID still 0xE5.
- Burst read command 0xFF for 2 bytes (MB wrap from 0x3F to 0x00) -> 0x00 then 0xE5; i_rst asserted mid-read -> SDO=1, oe=0, next transaction decodes correctly.
